// File: rtl/exu_alu_pipe_ctl.sv
// Pipelined integer ALU for the EXU: valid/ready op intake, E1 branch/jump resolution, tagged
// results after PIPE_STAGES cycles. Define EXU_ALU_ZBB_EN to add CLZ/CTZ/CPOP (ops 24-26).
module exu_alu_pipe_ctl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             scan_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [XLEN-2:0]  in_pc,
  input  logic [11:0]      in_brimm,
  input  logic             in_pc4,
  input  logic             in_pred_t,
  input  logic             flush,
  input  logic             freeze,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             flush_upper,
  output logic [XLEN-2:0]  flush_path,
  output logic             pred_correct
);
  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = ShW + 1;
  localparam int unsigned PcW  = XLEN - 1;

  typedef enum logic [4:0] {
    OpAdd  = 5'd0,  OpSub  = 5'd1,  OpAnd  = 5'd2,  OpOr   = 5'd3,  OpXor  = 5'd4,
    OpSll  = 5'd5,  OpSrl  = 5'd6,  OpSra  = 5'd7,  OpSlt  = 5'd8,  OpSltu = 5'd9,
    OpMin  = 5'd10, OpMinu = 5'd11, OpMax  = 5'd12, OpMaxu = 5'd13,
    OpBeq  = 5'd16, OpBne  = 5'd17, OpBlt  = 5'd18, OpBge  = 5'd19, OpBltu = 5'd20,
    OpBgeu = 5'd21, OpJal  = 5'd22, OpJalr = 5'd23, OpClz  = 5'd24, OpCtz  = 5'd25,
    OpCpop = 5'd26
  } op_e;

  // E1 operand/control registers
  op_e              e1_op_q;
  logic [TAG_W-1:0] e1_tag_q;
  logic [XLEN-1:0]  e1_a_q, e1_b_q;
  logic [PcW-1:0]   e1_pc_q;
  logic [11:0]      e1_brimm_q;
  logic             e1_pc4_q, e1_pred_q;

  logic [PIPE_STAGES-1:0] v_q, v_d;
  logic                   stall, accept;

  logic [XLEN-1:0]  alu_res, sum;
  logic [ShW-1:0]   shamt;
  logic             lt_s, lt_u;
  logic [PcW-1:0]   link_h, target_h, path;
  logic             is_br, is_jmp, taken, mispredict, redirect;

  logic [XLEN-1:0]  res_s [PIPE_STAGES];
  logic [TAG_W-1:0] tag_s [PIPE_STAGES];

  // Handshake and stall control
  assign out_valid    = v_q[PIPE_STAGES-1];
  assign stall        = freeze | (out_valid & ~out_ready);
  assign flush_upper  = v_q[0] & redirect & ~flush & ~stall;
  assign pred_correct = v_q[0] & is_br & ~mispredict & ~flush & ~stall;
  assign flush_path   = flush_upper ? path : '0;
  assign in_ready     = ~stall & ~flush_upper & ~flush;
  assign accept       = in_valid & in_ready;

  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else if (!stall) begin
      v_d[0] = accept;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        v_d[k] = v_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // scan_mode holds data-flop enables open, as an ICG test enable would
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      e1_op_q    <= OpAdd;
      e1_tag_q   <= '0;
      e1_a_q     <= '0;
      e1_b_q     <= '0;
      e1_pc_q    <= '0;
      e1_brimm_q <= '0;
      e1_pc4_q   <= 1'b0;
      e1_pred_q  <= 1'b0;
    end else if (accept | scan_mode) begin
      e1_op_q    <= op_e'(in_op);
      e1_tag_q   <= in_tag;
      e1_a_q     <= in_a;
      e1_b_q     <= in_b;
      e1_pc_q    <= in_pc;
      e1_brimm_q <= in_brimm;
      e1_pc4_q   <= in_pc4;
      e1_pred_q  <= in_pred_t;
    end
  end

`ifdef EXU_ALU_ZBB_EN
  logic [CntW-1:0] clz, ctz, cpop;
  always_comb begin
    clz  = CntW'(XLEN);
    ctz  = CntW'(XLEN);
    cpop = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (e1_a_q[i]) begin
        clz  = CntW'(XLEN - 1 - i);
        cpop = cpop + CntW'(1);
      end
    end
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (e1_a_q[i]) ctz = CntW'(i);
    end
  end
`endif

  assign sum   = e1_a_q + e1_b_q;
  assign shamt = e1_b_q[ShW-1:0];
  assign lt_s  = $signed(e1_a_q) < $signed(e1_b_q);
  assign lt_u  = e1_a_q < e1_b_q;

  always_comb begin
    alu_res = '0;
    case (e1_op_q)
      OpAdd:         alu_res = sum;
      OpSub:         alu_res = e1_a_q - e1_b_q;
      OpAnd:         alu_res = e1_a_q & e1_b_q;
      OpOr:          alu_res = e1_a_q | e1_b_q;
      OpXor:         alu_res = e1_a_q ^ e1_b_q;
      OpSll:         alu_res = e1_a_q << shamt;
      OpSrl:         alu_res = e1_a_q >> shamt;
      OpSra:         alu_res = $unsigned($signed(e1_a_q) >>> shamt);
      OpSlt:         alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OpSltu:        alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OpMin:         alu_res = lt_s ? e1_a_q : e1_b_q;
      OpMinu:        alu_res = lt_u ? e1_a_q : e1_b_q;
      OpMax:         alu_res = lt_s ? e1_b_q : e1_a_q;
      OpMaxu:        alu_res = lt_u ? e1_b_q : e1_a_q;
      OpJal, OpJalr: alu_res = {link_h, 1'b0};
`ifdef EXU_ALU_ZBB_EN
      OpClz:         alu_res = {{(XLEN-CntW){1'b0}}, clz};
      OpCtz:         alu_res = {{(XLEN-CntW){1'b0}}, ctz};
      OpCpop:        alu_res = {{(XLEN-CntW){1'b0}}, cpop};
`endif
      default:       alu_res = '0;
    endcase
  end

  // Branch resolution works on halfword addresses, so bit 0 is never carried
  always_comb begin
    link_h   = e1_pc_q + (e1_pc4_q ? PcW'(2) : PcW'(1));
    target_h = e1_pc_q + {{(PcW-12){e1_brimm_q[11]}}, e1_brimm_q};
    is_br    = 1'b0;
    taken    = 1'b0;
    case (e1_op_q)
      OpBeq:   begin is_br = 1'b1; taken = (e1_a_q == e1_b_q); end
      OpBne:   begin is_br = 1'b1; taken = (e1_a_q != e1_b_q); end
      OpBlt:   begin is_br = 1'b1; taken = lt_s;               end
      OpBge:   begin is_br = 1'b1; taken = ~lt_s;              end
      OpBltu:  begin is_br = 1'b1; taken = lt_u;               end
      OpBgeu:  begin is_br = 1'b1; taken = ~lt_u;              end
      default: ;
    endcase
    is_jmp     = (e1_op_q == OpJal) | (e1_op_q == OpJalr);
    mispredict = is_br & (taken ^ e1_pred_q);
    redirect   = is_jmp | mispredict;
    path       = is_jmp ? sum[XLEN-1:1] : (taken ? target_h : link_h);
  end

  // Result stages: stage 0 is the combinational E1 result, later stages are flopped
  assign res_s[0] = alu_res;
  assign tag_s[0] = e1_tag_q;

  for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_stage
    logic [XLEN-1:0]  res_q;
    logic [TAG_W-1:0] tag_q;
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        res_q <= '0;
        tag_q <= '0;
      end else if ((~stall & v_q[k-1]) | scan_mode) begin
        res_q <= res_s[k-1];
        tag_q <= tag_s[k-1];
      end
    end
    assign res_s[k] = res_q;
    assign tag_s[k] = tag_q;
  end

  assign out_data = res_s[PIPE_STAGES-1];
  assign out_tag  = tag_s[PIPE_STAGES-1];

endmodule

// File: tb/tb_exu_alu_pipe_ctl.sv
// Self-checking bench for exu_alu_pipe_ctl: queue-based reference model with per-cycle compare,
// directed corner cases, and a second XLEN=64 / PIPE_STAGES=1 instance.
module tb_exu_alu_pipe_ctl;
  localparam int NS = 2;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    bit          redir;
    logic [30:0] path;
    bit          ok;
    int          age;
  } ent_t;

  logic        clk, rst_l, scan_mode;
  logic        in_valid, in_ready, in_pc4, in_pred_t, flush, freeze, out_ready;
  logic [4:0]  in_op;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] in_a, in_b, out_data;
  logic [30:0] in_pc, flush_path;
  logic [11:0] in_brimm;
  logic        out_valid, flush_upper, pred_correct;

  logic        w_in_valid, w_in_ready, w_out_ready, w_out_valid, w_flush_upper, w_pred_correct;
  logic [4:0]  w_in_op;
  logic [3:0]  w_out_tag;
  logic [63:0] w_in_a, w_in_b, w_out_data;
  logic [62:0] w_in_pc, w_flush_path;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  exu_alu_pipe_ctl #(.XLEN(32), .PIPE_STAGES(NS), .TAG_W(4)) u_dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_pc(in_pc),
    .in_brimm(in_brimm), .in_pc4(in_pc4), .in_pred_t(in_pred_t), .flush(flush),
    .freeze(freeze), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_tag(out_tag), .flush_upper(flush_upper), .flush_path(flush_path),
    .pred_correct(pred_correct)
  );

  exu_alu_pipe_ctl #(.XLEN(64), .PIPE_STAGES(1), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .in_op(w_in_op), .in_tag(4'd9), .in_a(w_in_a), .in_b(w_in_b),
    .in_pc(w_in_pc), .in_brimm(12'd0), .in_pc4(1'b1), .in_pred_t(1'b0), .flush(1'b0),
    .freeze(1'b0), .out_ready(w_out_ready), .out_valid(w_out_valid), .out_data(w_out_data),
    .out_tag(w_out_tag), .flush_upper(w_flush_upper), .flush_path(w_flush_path),
    .pred_correct(w_pred_correct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one op must produce, from plain integer arithmetic
  function automatic ent_t ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [30:0] pc, input logic [11:0] bi, input bit pc4,
                                  input bit pt, input logic [3:0] tag);
    ent_t   e;
    longint sa, sb, ua, ub, pcv, lnk, tgt, off;
    int     sh, n;
    bit     tk, isbr;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    sh = int'(b[4:0]);
    pcv = longint'(pc) * 2;
    lnk = pcv + (pc4 ? 4 : 2);
    off = longint'(bi);
    if (bi[11]) off = off - 4096;
    tgt = pcv + off * 2;
    e.res = '0; e.tag = tag; e.redir = 0; e.path = '0; e.ok = 0; e.age = 1;
    tk = 0; isbr = 0;
    case (int'(op))
      0:  e.res = 32'(ua + ub);
      1:  e.res = 32'(ua - ub);
      2:  e.res = a & b;
      3:  e.res = a | b;
      4:  e.res = a ^ b;
      5:  e.res = 32'(ua << sh);
      6:  e.res = 32'(ua >> sh);
      7:  e.res = 32'(sa >>> sh);
      8:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      9:  e.res = (ua < ub) ? 32'd1 : 32'd0;
      10: e.res = (sa < sb) ? a : b;
      11: e.res = (ua < ub) ? a : b;
      12: e.res = (sa < sb) ? b : a;
      13: e.res = (ua < ub) ? b : a;
      16: begin isbr = 1; tk = (a == b); end
      17: begin isbr = 1; tk = (a != b); end
      18: begin isbr = 1; tk = (sa < sb); end
      19: begin isbr = 1; tk = (sa >= sb); end
      20: begin isbr = 1; tk = (ua < ub); end
      21: begin isbr = 1; tk = (ua >= ub); end
      22, 23: begin e.res = 32'(lnk); e.redir = 1; e.path = 31'((ua + ub) >> 1); end
`ifdef EXU_ALU_ZBB_EN
      24: begin n = 0; while (n < 32 && !a[31-n]) n++; e.res = 32'(n); end
      25: begin n = 0; while (n < 32 && !a[n]) n++; e.res = 32'(n); end
      26: e.res = 32'($countones(a));
`endif
      default: e.res = '0;
    endcase
    if (isbr) begin
      e.redir = (tk != pt);
      e.ok    = (tk == pt);
      e.path  = tk ? 31'(tgt >> 1) : 31'(lnk >> 1);
    end
    return e;
  endfunction

  // Per-cycle compare against the model, then advance the model across the clock edge
  task automatic cycle();
    bit   ov, st, he1, fu, pok, rdy;
    ent_t nxt, e1;
    #1;
    ov  = q.size() > 0 && q[0].age == NS;
    st  = freeze || (ov && !out_ready);
    he1 = q.size() > 0 && q[q.size()-1].age == 1;
    if (he1) e1 = q[q.size()-1];
    fu  = he1 && e1.redir && !flush && !st;
    pok = he1 && e1.ok && !flush && !st;
    rdy = !st && !fu && !flush;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, ov);
    if (ov) begin
      chk("out_data", out_data, q[0].res);
      chk("out_tag", out_tag, q[0].tag);
    end
    chk("flush_upper", flush_upper, fu);
    chk("flush_path", flush_path, fu ? e1.path : 31'd0);
    chk("pred_correct", pred_correct, pok);
    nxt = ref_op(in_op, in_a, in_b, in_pc, in_brimm, in_pc4, in_pred_t, in_tag);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else if (!st) begin
      if (ov) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (in_valid && rdy) q.push_back(nxt);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_op = '0; in_tag = '0; in_a = '0; in_b = '0; in_pc = '0; in_brimm = '0;
    in_pc4 = 0; in_pred_t = 0; flush = 0; freeze = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] pc, input logic [11:0] bi,
                       input bit pc4, input bit pt);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag; in_pc = pc[31:1];
    in_brimm = bi; in_pc4 = pc4; in_pred_t = pt;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_flush_upper"}, flush_upper, 0);
    chk({pfx, "_pred_correct"}, pred_correct, 0);
    chk({pfx, "_out_data"}, out_data, 0);
    chk({pfx, "_out_tag"}, out_tag, 0);
    chk({pfx, "_flush_path"}, flush_path, 0);
  endtask

  int op_tab[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 16, 17, 18, 19, 20, 21,
                    22, 23, 24, 25, 26, 14, 31};

  initial begin
    ent_t m;
    scan_mode = 0; rst_l = 0;
    idle();
    w_in_valid = 0; w_in_op = '0; w_in_a = '0; w_in_b = '0; w_in_pc = '0; w_out_ready = 1;
    #3;
    chk_reset_outputs("rst");
    chk("rst_in_ready", in_ready, 1);
    chk("rst64_out_valid", w_out_valid, 0);
    @(negedge clk);
    rst_l = 1;

    // Pin the model with hand-computed values
    m = ref_op(5'd0, 32'd7, 32'hFFFF_FFFF, '0, '0, 0, 0, 4'd3);
    chk("model_add", m.res, 32'd6);
    m = ref_op(5'd18, 32'hFFFF_FFFF, 32'd1, 31'h80, 12'h010, 1, 0, 4'd0);
    chk("model_blt_path", m.path, 31'h90);
    m = ref_op(5'd7, 32'h8000_0000, 32'd31, '0, '0, 0, 0, 4'd0);
    chk("model_sra", m.res, 32'hFFFF_FFFF);

    // ADD with wrap-around, two-cycle latency
    issue(5'd0, 32'd7, 32'hFFFF_FFFF, 4'd3, 32'h0, 12'h0, 1, 0);
    cycle();
    idle();
    cycle();
    #1;
    chk("add_out_valid", out_valid, 1);
    chk("add_out_data", out_data, 32'd6);
    chk("add_out_tag", out_tag, 4'd3);
    cycle();

    // BLT taken but predicted not taken
    issue(5'd18, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'h100, 12'h010, 1, 0);
    cycle();
    idle();
    #1;
    chk("blt_flush_upper", flush_upper, 1);
    chk("blt_flush_path", flush_path, 31'h90);
    chk("blt_pred_correct", pred_correct, 0);
    chk("blt_in_ready", in_ready, 0);
    cycle();
    cycle();

    // Back-pressure: three back-to-back ops, results drain in order
    out_ready = 0;
    issue(5'd0, 32'd1, 32'd1, 4'd1, 32'h0, 12'h0, 1, 0);
    cycle();
    issue(5'd0, 32'd2, 32'd2, 4'd2, 32'h0, 12'h0, 1, 0);
    cycle();
    issue(5'd0, 32'd3, 32'd3, 4'd3, 32'h0, 12'h0, 1, 0);
    #1;
    chk("bp_in_ready_full", in_ready, 0);
    cycle();
    cycle();
    out_ready = 1;
    #1;
    chk("bp_first_tag", out_tag, 4'd1);
    chk("bp_in_ready_resume", in_ready, 1);
    cycle();
    idle();
    #1;
    chk("bp_second_tag", out_tag, 4'd2);
    cycle();
    #1;
    chk("bp_third_tag", out_tag, 4'd3);
    chk("bp_third_data", out_data, 32'd6);
    cycle();
    #1;
    chk("bp_drained", out_valid, 0);
    cycle();

    // flush while a mispredicted BNE is in E1
    issue(5'd17, 32'd1, 32'd2, 4'd4, 32'h40, 12'h008, 1, 0);
    cycle();
    idle();
    flush = 1;
    #1;
    chk("flush_no_upper", flush_upper, 0);
    chk("flush_in_ready", in_ready, 0);
    cycle();
    flush = 0;
    #1;
    chk("flush_empty", out_valid, 0);
    cycle();
    #1;
    chk("flush_empty2", out_valid, 0);
    cycle();

    // JAL: link result, redirect to a+b
    issue(5'd22, 32'h300, 32'd4, 4'd5, 32'h200, 12'h0, 1, 0);
    cycle();
    idle();
    #1;
    chk("jal_flush_upper", flush_upper, 1);
    chk("jal_flush_path", flush_path, 31'h182);
    chk("jal_pred_correct", pred_correct, 0);
    cycle();
    #1;
    chk("jal_out_data", out_data, 32'h204);
    cycle();

`ifdef EXU_ALU_ZBB_EN
    issue(5'd24, 32'd0, 32'd0, 4'd6, 32'h0, 12'h0, 1, 0);
    cycle();
    idle();
    cycle();
    #1;
    chk("clz_zero", out_data, 32'd32);
    cycle();
`endif

    // 64-bit, single-stage instance: SRA sign fill and coincident redirect/out_valid
    w_in_valid = 1; w_in_op = 5'd7; w_in_a = 64'h8000_0000_0000_0000; w_in_b = 64'd63;
    @(negedge clk);
    w_in_valid = 0;
    #1;
    chk("x64_sra_valid", w_out_valid, 1);
    chk("x64_sra_data", w_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    w_in_valid = 1; w_in_op = 5'd22; w_in_a = 64'h300; w_in_b = 64'd4; w_in_pc = 63'h100;
    w_out_ready = 0;
    @(negedge clk);
    w_in_valid = 0;
    #1;
    chk("x64_jal_valid", w_out_valid, 1);
    chk("x64_jal_stalled_upper", w_flush_upper, 0);
    chk("x64_jal_stalled_ready", w_in_ready, 0);
    @(negedge clk);
    w_out_ready = 1;
    #1;
    chk("x64_jal_upper", w_flush_upper, 1);
    chk("x64_jal_path", w_flush_path, 63'h182);
    chk("x64_jal_data", w_out_data, 64'h204);
    chk("x64_jal_tag", w_out_tag, 4'd9);
    @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = $urandom_range(0, 99) < 70;
      in_op     = 5'(op_tab[$urandom_range(0, op_tab.size() - 1)]);
      case ($urandom_range(0, 3))
        0:       in_a = 32'($urandom_range(0, 40));
        1:       in_a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        default: in_a = $urandom();
      endcase
      case ($urandom_range(0, 3))
        0:       in_b = in_a;
        1:       in_b = 32'($urandom_range(0, 40));
        default: in_b = $urandom();
      endcase
      in_tag    = 4'($urandom());
      in_pc     = 31'($urandom());
      in_brimm  = 12'($urandom());
      in_pc4    = 1'($urandom());
      in_pred_t = 1'($urandom());
      flush     = $urandom_range(0, 99) < 4;
      freeze    = $urandom_range(0, 99) < 10;
      out_ready = $urandom_range(0, 99) < 70;
      cycle();
    end

    // Asynchronous reset with ops in flight
    idle();
    out_ready = 0;
    issue(5'd4, 32'hA5A5_5A5A, 32'hFFFF_0000, 4'd7, 32'h0, 12'h0, 1, 0);
    cycle();
    issue(5'd23, 32'h1000, 32'd8, 4'd8, 32'h80, 12'h0, 0, 0);
    cycle();
    idle();
    #2;
    rst_l = 0;
    #1;
    chk_reset_outputs("arst");
    q.delete();
    @(negedge clk);
    rst_l = 1;
    for (int c = 0; c < 4; c++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
